// File: rtl/library_pkg.sv
// Shared constants, state encoding and read-index map for library_checker.
// CHK_FIRST_FAIL_EN widens the read index to 4 bits and adds the first-fail helper.
package library_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int TOT_W_DEF = 16;
  localparam int NUM_OUT   = 6;

`ifdef CHK_FIRST_FAIL_EN
  localparam int RD_SEL_W = 4;
`else
  localparam int RD_SEL_W = 3;
`endif

  localparam logic [2:0] IDX_NOT  = 3'd0;
  localparam logic [2:0] IDX_NAND = 3'd1;
  localparam logic [2:0] IDX_NOR  = 3'd2;
  localparam logic [2:0] IDX_MUX  = 3'd3;
  localparam logic [2:0] IDX_Q    = 3'd4;
  localparam logic [2:0] IDX_QN   = 3'd5;
  localparam logic [2:0] IDX_TOT  = 3'd6;
  localparam logic [2:0] IDX_SUM  = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    CHECK  = 2'd2,
    REPORT = 2'd3
  } state_e;

`ifdef CHK_FIRST_FAIL_EN
  // Lowest-numbered mismatching output wins when several fail together.
  function automatic logic [2:0] first_set(input logic [NUM_OUT-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = NUM_OUT - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction
`endif

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; cleared only by reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (inc && !(&value_q)) value_d = value_q + W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/library_checker.sv
// Golden-model checker for the cell-library bench with saturating error counters and a read port.
// Optional first-fail capture (check index + output index) is built when CHK_FIRST_FAIL_EN is defined.
module library_checker
  import library_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TOT_W = TOT_W_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ENB,
  input  logic                iA,
  input  logic                iB,
  input  logic                D,
  input  logic                SEL,
  input  logic                NOT,
  input  logic                NAND,
  input  logic                NOR,
  input  logic                MUX,
  input  logic                Q,
  input  logic                Qn,
  input  logic                STOP,
  input  logic                RD_REQ,
  input  logic [RD_SEL_W-1:0] RD_SEL,
  output logic [TOT_W-1:0]    RD_DATA,
  output logic                RD_ACK,
  output logic                BUSY,
  output logic                PASS,
  output state_e              state_o
);

  localparam int SUM_W = TOT_W + 3;

  state_e state_q, state_d;
  logic   enb_prev_q;
  logic   shadow_q;
  logic   shadow_valid_q;
  logic   pass_q, pass_d;
  logic   rd_ack_q;
  logic [TOT_W-1:0] rd_data_q;

  logic                check_en;
  logic [NUM_OUT-1:0]  mism;
  logic [NUM_OUT-1:0]  err_inc;
  logic [CNT_W-1:0]    err_cnt [NUM_OUT];
  logic [TOT_W-1:0]    tot_cnt;
  logic [SUM_W-1:0]    sum_wide;
  logic [TOT_W-1:0]    sum_sat;
  logic                any_cnt;
  logic [TOT_W-1:0]    rd_val;

  assign check_en = (state_q == CHECK);

  // Q/Qn expectations come from the shadow, which mirrors the library flop one edge late.
  always_comb begin
    mism           = '0;
    mism[IDX_NOT]  = (NOT  != ~iA);
    mism[IDX_NAND] = (NAND != ~(iA & iB));
    mism[IDX_NOR]  = (NOR  != ~(iA | iB));
    mism[IDX_MUX]  = (MUX  != (SEL ? iB : iA));
    mism[IDX_Q]    = shadow_valid_q & (Q  != shadow_q);
    mism[IDX_QN]   = shadow_valid_q & (Qn != ~shadow_q);
  end

  assign err_inc = mism & {NUM_OUT{check_en}};

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_err
    sat_counter #(.W(CNT_W)) u_err_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (err_inc[g]),
      .value (err_cnt[g])
    );
  end

  sat_counter #(.W(TOT_W)) u_tot_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (check_en),
    .value (tot_cnt)
  );

  always_comb begin
    sum_wide = '0;
    any_cnt  = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      sum_wide = sum_wide + SUM_W'(err_cnt[i]);
      any_cnt  = any_cnt | (|err_cnt[i]);
    end
    sum_sat = (|sum_wide[SUM_W-1:TOT_W]) ? '1 : sum_wide[TOT_W-1:0];
  end

  // PASS folds in the final checked edge, whose increments have not landed yet.
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE:  state_d = ARM;
      ARM:   if (ENB && !enb_prev_q) state_d = CHECK;
      CHECK: begin
        if (STOP || !ENB) begin
          state_d = REPORT;
          pass_d  = !any_cnt && !(|err_inc);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= IDLE;
      enb_prev_q     <= 1'b1;
      shadow_q       <= 1'b0;
      shadow_valid_q <= 1'b0;
      pass_q         <= 1'b0;
    end else begin
      state_q    <= state_d;
      enb_prev_q <= ENB;
      pass_q     <= pass_d;
      if (ENB) shadow_q <= D;
      if (check_en && ENB) shadow_valid_q <= 1'b1;
    end
  end

`ifdef CHK_FIRST_FAIL_EN
  logic             ff_valid_q;
  logic [TOT_W-1:0] ff_cycle_q;
  logic [2:0]       ff_out_q;

  // The pre-edge total is the zero-based index of the check being evaluated.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ff_valid_q <= 1'b0;
      ff_cycle_q <= '0;
      ff_out_q   <= '0;
    end else if ((|err_inc) && !ff_valid_q) begin
      ff_valid_q <= 1'b1;
      ff_cycle_q <= tot_cnt;
      ff_out_q   <= first_set(err_inc);
    end
  end
`endif

  always_comb begin
    rd_val = '0;
    case (RD_SEL)
      RD_SEL_W'(IDX_NOT):  rd_val = TOT_W'(err_cnt[IDX_NOT]);
      RD_SEL_W'(IDX_NAND): rd_val = TOT_W'(err_cnt[IDX_NAND]);
      RD_SEL_W'(IDX_NOR):  rd_val = TOT_W'(err_cnt[IDX_NOR]);
      RD_SEL_W'(IDX_MUX):  rd_val = TOT_W'(err_cnt[IDX_MUX]);
      RD_SEL_W'(IDX_Q):    rd_val = TOT_W'(err_cnt[IDX_Q]);
      RD_SEL_W'(IDX_QN):   rd_val = TOT_W'(err_cnt[IDX_QN]);
      RD_SEL_W'(IDX_TOT):  rd_val = tot_cnt;
      RD_SEL_W'(IDX_SUM):  rd_val = sum_sat;
`ifdef CHK_FIRST_FAIL_EN
      RD_SEL_W'(8):        rd_val = ff_valid_q ? ff_cycle_q : '1;
      RD_SEL_W'(9):        rd_val = ff_valid_q ? TOT_W'(ff_out_q) : '1;
`endif
      default:             rd_val = '0;
    endcase
  end

  // Read port: a request sampled on an edge is answered on the next cycle with
  // RD_ACK high for one cycle and RD_DATA loaded; there is no back-pressure and
  // RD_DATA keeps its last value while RD_ACK is low.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q <= RD_REQ;
      if (RD_REQ) rd_data_q <= rd_val;
    end
  end

  assign RD_DATA = rd_data_q;
  assign RD_ACK  = rd_ack_q;
  assign BUSY    = check_en;
  assign PASS    = pass_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_library_checker.sv
// Directed bench for library_checker: a behavioural library with injectable faults feeds the checker.
module tb_library_checker;
  import library_pkg::*;

  localparam int TOT_W = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ENB = 1'b0, iA = 1'b0, iB = 1'b0, D = 1'b0, SEL = 1'b0;
  logic STOP = 1'b0, RD_REQ = 1'b0;
  logic [RD_SEL_W-1:0] RD_SEL = '0;
  logic [TOT_W-1:0] RD_DATA;
  logic RD_ACK, BUSY, PASS;
  state_e state_o;

  logic not_l, nand_l, nor_l, mux_l, q_l, qn_l, lib_q;
  bit f_not = 0, f_nand1 = 0, f_q0 = 0, mux_flip = 0;

  int pass_cnt = 0, check_cnt = 0, fail_cnt = 0;
  logic [TOT_W-1:0] exp_q[$];

  bit va [18] = '{0,0,1,1, 0,0,1,1, 0,0,0,0,0,0,0,0,0,0};
  bit vb [18] = '{0,1,0,1, 0,1,0,1, 0,0,0,0,0,0,0,0,0,0};
  bit vs [18] = '{0,0,0,0, 1,1,1,1, 0,0,0,0,0,0,0,0,0,0};
  bit vd [18] = '{0,0,0,0, 0,0,0,0, 1,0,1,0,1,0,1,0,1,0};

  // Clock / reset, and the library under test with fault knobs.
  always #5 CLK = ~CLK;

  always @(posedge CLK or posedge RST) begin
    if (RST)      lib_q <= 1'b0;
    else if (ENB) lib_q <= D;
  end

  assign not_l  = f_not   ? iA   : ~iA;
  assign nand_l = f_nand1 ? 1'b1 : ~(iA & iB);
  assign nor_l  = ~(iA | iB);
  assign mux_l  = (SEL ? iB : iA) ^ mux_flip;
  assign q_l    = f_q0 ? 1'b0 : lib_q;
  assign qn_l   = f_q0 ? 1'b1 : ~lib_q;

  library_checker dut (
    .CLK(CLK), .RST(RST), .ENB(ENB), .iA(iA), .iB(iB), .D(D), .SEL(SEL),
    .NOT(not_l), .NAND(nand_l), .NOR(nor_l), .MUX(mux_l), .Q(q_l), .Qn(qn_l),
    .STOP(STOP), .RD_REQ(RD_REQ), .RD_SEL(RD_SEL), .RD_DATA(RD_DATA),
    .RD_ACK(RD_ACK), .BUSY(BUSY), .PASS(PASS), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: all inputs change on the falling edge, outputs are sampled there too.
  task automatic do_read(input string tag, input int sel, input logic [TOT_W-1:0] exp);
    RD_REQ = 1'b1;
    RD_SEL = RD_SEL_W'(sel);
    exp_q.push_back(exp);
    @(negedge CLK);
    RD_REQ = 1'b0;
    chk({tag, "_ack"}, RD_ACK, 1);
    chk(tag, RD_DATA, exp_q.pop_front());
  endtask

  task automatic begin_run(input bit enb_high);
    RST = 1'b1; ENB = enb_high; STOP = 1'b0; RD_REQ = 1'b0;
    iA = 0; iB = 0; SEL = 0; D = 0;
    f_not = 0; f_nand1 = 0; f_q0 = 0; mux_flip = 0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("arm_after_idle", state_o, ARM);
    if (enb_high) begin
      @(negedge CLK);
      chk("arm_waits_for_low", state_o, ARM);
      ENB = 1'b0;
      @(negedge CLK);
    end
    ENB = 1'b1;
    D   = 1'b1;
    @(negedge CLK);
    chk("busy_in_check", BUSY, 1);
  endtask

  task automatic run_vectors(input bit end_by_enb, input int rd_at, input int rd_sel,
                             input logic [TOT_W-1:0] rd_exp, input int flip_at);
    for (int i = 0; i < 18; i++) begin
      iA = va[i]; iB = vb[i]; SEL = vs[i]; D = vd[i];
      mux_flip = (i == flip_at);
      RD_REQ   = (i == rd_at);
      RD_SEL   = RD_SEL_W'(rd_sel);
      if (i == rd_at) exp_q.push_back(rd_exp);
      if (i == 17) begin
        if (end_by_enb) ENB = 1'b0;
        else            STOP = 1'b1;
      end
      @(negedge CLK);
      if (i == rd_at) begin
        chk("mid_read_ack", RD_ACK, 1);
        chk("mid_read_data", RD_DATA, exp_q.pop_front());
      end
    end
    STOP = 1'b0; RD_REQ = 1'b0; mux_flip = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge CLK);
    chk("rst_state", state_o, IDLE);
    chk("rst_rd_data", RD_DATA, 0);
    chk("rst_rd_ack", RD_ACK, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_pass", PASS, 0);

    // Clean library: 18 checks, no errors
    begin_run(1'b0);
    run_vectors(1'b0, -1, 0, '0, -1);
    chk("clean_state", state_o, REPORT);
    chk("clean_busy", BUSY, 0);
    chk("clean_pass", PASS, 1);
    do_read("clean_nand", IDX_NAND, 0);
    do_read("clean_q", IDX_Q, 0);
    // Held request: one ack per cycle, data holds afterwards
    RD_REQ = 1'b1; RD_SEL = RD_SEL_W'(IDX_SUM); exp_q.push_back(16'd0);
    @(negedge CLK);
    RD_SEL = RD_SEL_W'(IDX_TOT); exp_q.push_back(16'd18);
    chk("held_ack0", RD_ACK, 1);
    chk("clean_sum", RD_DATA, exp_q.pop_front());
    @(negedge CLK);
    RD_REQ = 1'b0;
    chk("held_ack1", RD_ACK, 1);
    chk("clean_total", RD_DATA, exp_q.pop_front());
    @(negedge CLK);
    chk("idle_ack_low", RD_ACK, 0);
    chk("data_holds", RD_DATA, 18);
`ifdef CHK_FIRST_FAIL_EN
    do_read("clean_ff_cycle", 8, 16'hFFFF);
    do_read("clean_ff_out", 9, 16'hFFFF);
`endif

    // NAND stuck high; ENB already high out of reset
    begin_run(1'b1);
    f_nand1 = 1'b1;
    run_vectors(1'b0, -1, 0, '0, -1);
    chk("nand_pass", PASS, 0);
    do_read("nand_cnt", IDX_NAND, 2);
    do_read("nand_sum", IDX_SUM, 2);
    do_read("nand_not", IDX_NOT, 0);
    do_read("nand_total", IDX_TOT, 18);

    // Q stuck low, run ended by ENB falling; read after check 1 sees no Q error
    begin_run(1'b0);
    f_q0 = 1'b1;
    run_vectors(1'b1, 1, IDX_Q, 16'd0, -1);
    chk("qstuck_state", state_o, REPORT);
    chk("qstuck_pass", PASS, 0);
    do_read("qstuck_q", IDX_Q, 5);
    do_read("qstuck_qn", IDX_QN, 5);
    do_read("qstuck_sum", IDX_SUM, 10);
    do_read("qstuck_total", IDX_TOT, 18);

    // NOT inverted for 300 checks: counter saturates
    begin_run(1'b0);
    f_not = 1'b1;
    for (int i = 0; i < 300; i++) begin
      iA = 1'($urandom_range(0, 1));
      iB = 1'($urandom_range(0, 1));
      SEL = 1'($urandom_range(0, 1));
      D = 1'($urandom_range(0, 1));
      STOP = (i == 299);
      @(negedge CLK);
    end
    STOP = 1'b0;
    do_read("sat_not", IDX_NOT, 255);
    do_read("sat_sum", IDX_SUM, 255);
    do_read("sat_total", IDX_TOT, 300);
    do_read("sat_nand", IDX_NAND, 0);

    // Asynchronous reset in the middle of CHECK
    begin_run(1'b0);
    f_not = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iA = 1'(i & 1);
      RD_REQ = (i == 3);
      RD_SEL = RD_SEL_W'(IDX_NOT);
      if (i == 3) exp_q.push_back(16'd3);
      @(negedge CLK);
      if (i == 3) chk("pre_rst_not", RD_DATA, exp_q.pop_front());
    end
    RD_REQ = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("async_rst_state", state_o, IDLE);
    chk("async_rst_busy", BUSY, 0);
    chk("async_rst_data", RD_DATA, 0);
    @(negedge CLK);
    RST = 1'b0; f_not = 1'b0;
    RD_REQ = 1'b1; RD_SEL = RD_SEL_W'(IDX_NOT); exp_q.push_back(16'd0);
    @(negedge CLK);
    RD_REQ = 1'b0;
    chk("post_rst_ack", RD_ACK, 1);
    chk("post_rst_not", RD_DATA, exp_q.pop_front());
    chk("post_rst_state", state_o, ARM);
    chk("post_rst_busy", BUSY, 0);
    do_read("post_rst_total", IDX_TOT, 0);

`ifdef CHK_FIRST_FAIL_EN
    // Single MUX fault on check 6
    begin_run(1'b0);
    run_vectors(1'b0, -1, 0, '0, 5);
    do_read("ff_cycle", 8, 5);
    do_read("ff_out", 9, 3);
    do_read("ff_mux_cnt", IDX_MUX, 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
